// File: rtl/circuit1_pkg.sv
// Shared definitions for circuit1_pipe: the widest supported operand width, the signed limits
// at that width, and a width-generic signed add that reports overflow and can saturate.
package circuit1_pkg;

    localparam int MAX_W = 32;

    typedef logic signed [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic  ovf;
        wide_t sum;
    } sat_res_t;

    localparam wide_t WIDE_MAX = {1'b0, {(MAX_W-1){1'b1}}};
    localparam wide_t WIDE_MIN = {1'b1, {(MAX_W-1){1'b0}}};

    // Narrow limits come from arithmetic shifts of the wide limits, so they are already sign-extended
    function automatic wide_t smax(input int w);
        return WIDE_MAX >>> (MAX_W - w);
    endfunction

    function automatic wide_t smin(input int w);
        return WIDE_MIN >>> (MAX_W - w);
    endfunction

    // a and b are w-bit values sign-extended to MAX_W. The full sum cannot overflow while w < MAX_W.
    // Overflow is therefore detected by checking whether the low w bits, re-extended, still equal it.
    function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int w,
                                         input logic sat);
        sat_res_t r;
        wide_t    full;
        wide_t    wrapped;
        full    = a + b;
        wrapped = (full <<< (MAX_W - w)) >>> (MAX_W - w);
        r.ovf   = (wrapped != full);
        if (r.ovf && sat) begin
            r.sum = full[MAX_W-1] ? smin(w) : smax(w);
        end else begin
            r.sum = wrapped;
        end
        return r;
    endfunction

endpackage

// File: rtl/dp_sadd_sat.sv
// W-bit signed adder with optional saturation.
// The overflow output reflects the unsaturated sum.
module dp_sadd_sat
    import circuit1_pkg::*;
#(
    parameter int W        = 8,
    parameter int SATURATE = 0
)
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    if (W < 2 || W >= MAX_W) begin : g_bad_width
        $error("dp_sadd_sat: W must lie in [2, MAX_W-1]");
    end

    sat_res_t res;
    logic     unused_hi;

    always_comb begin
        res = sat_add(wide_t'(a), wide_t'(b), W, SATURATE != 0);
    end

    assign sum       = res.sum[W-1:0];
    assign ovf       = res.ovf;
    assign unused_hi = ^res.sum[MAX_W-1:W];

endmodule

// File: rtl/circuit1_pipe.sv
// Two-stage stallable Circuit1 datapath: z = min(a+b, a+c), x = a*c - (a+b).
// It uses a valid/ready handshake on both sides and has a sticky overflow flag.
module circuit1_pipe
    import circuit1_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int SATURATE  = 0
)
(
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic signed [DATAWIDTH-1:0]   a,
    input  logic signed [DATAWIDTH-1:0]   b,
    input  logic signed [DATAWIDTH-1:0]   c,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [DATAWIDTH-1:0]   z,
    output logic signed [2*DATAWIDTH-1:0] x,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int W = DATAWIDTH;

    logic signed [W-1:0]   d_n, e_n, d, e;
    logic signed [2*W-1:0] a_x, c_x, f_n, f, d_x;
    logic                  ovd, ove, ov1;
    logic                  v1, v2;
    logic                  adv1, adv2, load1;

    dp_sadd_sat #(.W(W), .SATURATE(SATURATE)) u_add_d (
        .a   (a),
        .b   (b),
        .sum (d_n),
        .ovf (ovd)
    );

    dp_sadd_sat #(.W(W), .SATURATE(SATURATE)) u_add_e (
        .a   (a),
        .b   (c),
        .sum (e_n),
        .ovf (ove)
    );

    assign a_x = {{W{a[W-1]}}, a};
    assign c_x = {{W{c[W-1]}}, c};
    assign f_n = a_x * c_x;

    // Each stage may take new data when it is empty or its content is leaving this cycle
    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;
    assign load1    = in_valid && adv1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            v1  <= 1'b0;
            d   <= '0;
            e   <= '0;
            f   <= '0;
            ov1 <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
            end
            if (load1) begin
                d   <= d_n;
                e   <= e_n;
                f   <= f_n;
                ov1 <= ovd || ove;
            end
        end
    end

    assign d_x = {{W{d[W-1]}}, d};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            v2  <= 1'b0;
            z   <= '0;
            x   <= '0;
            ovf <= 1'b0;
        end else begin
            if (adv2) begin
                v2 <= v1;
            end
            if (adv2 && v1) begin
                z <= (d > e) ? e : d;
                x <= f - d_x;
            end
            // A flagged transaction entering stage 2 takes priority over a clear
            if (adv2 && v1 && ov1) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_circuit1_pipe.sv
// Bench for circuit1_pipe: directed scenarios on 8-bit wrap and saturate instances,
// then a random handshake sweep of all instances (including a 16-bit one) against an arithmetic model.
module tb_circuit1_pipe;

    localparam int SWEEP = 600;

    logic Clk = 1'b0;
    logic Rst;
    logic in_valid, out_ready, ovf_clr;
    logic signed [7:0]  a8, b8, c8;
    logic signed [15:0] a16, b16, c16;

    logic               in_ready_w, out_valid_w, ovf_w;
    logic signed [7:0]  z_w;
    logic signed [15:0] x_w;
    logic               in_ready_s, out_valid_s, ovf_s;
    logic signed [7:0]  z_s;
    logic signed [15:0] x_s;
    logic               in_ready_l, out_valid_l, ovf_l;
    logic signed [15:0] z_l;
    logic signed [31:0] x_l;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0][63:0] z;
        logic [2:0][63:0] x;
        logic [2:0]       ov;
    } exp_t;

    exp_t q[$];

    always #5 Clk = ~Clk;

    circuit1_pipe #(.DATAWIDTH(8), .SATURATE(0)) u_w (
        .Clk(Clk), .Rst(Rst), .a(a8), .b(b8), .c(c8),
        .in_valid(in_valid), .in_ready(in_ready_w), .z(z_w), .x(x_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .ovf(ovf_w), .ovf_clr(ovf_clr)
    );

    circuit1_pipe #(.DATAWIDTH(8), .SATURATE(1)) u_s (
        .Clk(Clk), .Rst(Rst), .a(a8), .b(b8), .c(c8),
        .in_valid(in_valid), .in_ready(in_ready_s), .z(z_s), .x(x_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .ovf(ovf_s), .ovf_clr(ovf_clr)
    );

    circuit1_pipe #(.DATAWIDTH(16), .SATURATE(1)) u_l (
        .Clk(Clk), .Rst(Rst), .a(a16), .b(b16), .c(c16),
        .in_valid(in_valid), .in_ready(in_ready_l), .z(z_l), .x(x_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .ovf(ovf_l), .ovf_clr(ovf_clr)
    );

    // Reference: plain integer arithmetic on the operand values
    function automatic void ref_calc(input longint av, input longint bv, input longint cv,
                                     input int w, input bit sat,
                                     output longint zr, output longint xr, output bit ovr);
        longint mx, mn, ds, es, d, e;
        bit od, oe;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        ds = av + bv;
        es = av + cv;
        od = (ds > mx) || (ds < mn);
        oe = (es > mx) || (es < mn);
        if (!od)      d = ds;
        else if (sat) d = (ds > mx) ? mx : mn;
        else          d = (ds > mx) ? ds - (longint'(1) <<< w) : ds + (longint'(1) <<< w);
        if (!oe)      e = es;
        else if (sat) e = (es > mx) ? mx : mn;
        else          e = (es > mx) ? es - (longint'(1) <<< w) : es + (longint'(1) <<< w);
        zr  = (d > e) ? e : d;
        xr  = av * cv - d;
        ovr = od || oe;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int av, input int bv, input int cv, input logic vld);
        a8  = 8'(av);
        b8  = 8'(bv);
        c8  = 8'(cv);
        a16 = 16'(av);
        b16 = 16'(bv);
        c16 = 16'(cv);
        in_valid = vld;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
        drive(0, 0, 0, 1'b0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if (out_valid_w !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_w); end
        n_cmp++; if (z_w !== 8'sd0) begin n_bad++; $display("FAIL reset_z: got %0d expected 0", z_w); end
        n_cmp++; if (x_w !== 16'sd0) begin n_bad++; $display("FAIL reset_x: got %0d expected 0", x_w); end
        n_cmp++; if (ovf_w !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ovf_w); end
        n_cmp++; if (in_ready_w !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_w); end
        n_cmp++; if (out_valid_l !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_l: got %b expected 0", out_valid_l); end
        tick();
        Rst = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive(3, 4, 5, 1'b1);
        @(negedge Clk);
        n_cmp++; if (in_ready_w !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready: got %b expected 1", in_ready_w); end
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        n_cmp++; if (out_valid_w !== 1'b0) begin n_bad++; $display("FAIL basic_latency_early: got %b expected 0", out_valid_w); end
        @(negedge Clk);
        n_cmp++; if (out_valid_w !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b expected 1", out_valid_w); end
        n_cmp++; if (z_w !== 8'sd7) begin n_bad++; $display("FAIL basic_z: got %0d expected 7", z_w); end
        n_cmp++; if (x_w !== 16'sd8) begin n_bad++; $display("FAIL basic_x: got %0d expected 8", x_w); end
        n_cmp++; if (ovf_w !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b expected 0", ovf_w); end
        tick();
    endtask

    task automatic test_overflow();
        drive(100, 100, 1, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        n_cmp++; if (z_w !== -8'sd56) begin n_bad++; $display("FAIL wrap_z: got %0d expected -56", z_w); end
        n_cmp++; if (x_w !== 16'sd156) begin n_bad++; $display("FAIL wrap_x: got %0d expected 156", x_w); end
        n_cmp++; if (ovf_w !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf: got %b expected 1", ovf_w); end
        n_cmp++; if (z_s !== 8'sd101) begin n_bad++; $display("FAIL sat_z: got %0d expected 101", z_s); end
        n_cmp++; if (x_s !== -16'sd27) begin n_bad++; $display("FAIL sat_x: got %0d expected -27", x_s); end
        n_cmp++; if (ovf_s !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b expected 1", ovf_s); end
        n_cmp++; if (x_l !== -32'sd100) begin n_bad++; $display("FAIL wide_x: got %0d expected -100", x_l); end
        n_cmp++; if (ovf_l !== 1'b0) begin n_bad++; $display("FAIL wide_ovf: got %b expected 0", ovf_l); end
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge Clk);
        n_cmp++; if (ovf_w !== 1'b0) begin n_bad++; $display("FAIL clr_ovf_w: got %b expected 0", ovf_w); end
        n_cmp++; if (ovf_s !== 1'b0) begin n_bad++; $display("FAIL clr_ovf_s: got %b expected 0", ovf_s); end
        // Clear asserted on the very edge the flagged transaction enters stage 2: the set must win
        tick();
        drive(100, 100, 1, 1'b1);
        tick();
        in_valid = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge Clk);
        n_cmp++; if (ovf_w !== 1'b1) begin n_bad++; $display("FAIL set_wins_ovf: got %b expected 1", ovf_w); end
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        longint k;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc == 6) out_ready = 1'b1;
            if (acc < 4) drive(acc + 1, acc + 1, acc + 1, 1'b1);
            else in_valid = 1'b0;
            @(negedge Clk);
            if (cyc == 3) begin
                n_cmp++; if (in_ready_w !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready_w); end
                n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
                n_cmp++; if (out_valid_w !== 1'b1) begin n_bad++; $display("FAIL bp_stall_valid: got %b expected 1", out_valid_w); end
                n_cmp++; if (z_w !== 8'sd2 || x_w !== -16'sd1) begin n_bad++; $display("FAIL bp_stall_data: got z=%0d x=%0d expected z=2 x=-1", z_w, x_w); end
            end
            if (in_valid && in_ready_w) acc++;
            if (out_valid_w && out_ready) begin
                k = longint'(got + 1);
                n_cmp++; if (longint'(z_w) !== 2 * k || longint'(x_w) !== k * k - 2 * k) begin
                    n_bad++; $display("FAIL bp_order_%0d: got z=%0d x=%0d expected z=%0d x=%0d", got, z_w, x_w, 2 * k, k * k - 2 * k);
                end
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL bp_drain_timeout: got %0d outputs expected 4", got); end
        tick();
        @(negedge Clk);
        n_cmp++; if (out_valid_w !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got out_valid %b expected 0", out_valid_w); end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(100, 100, 1, 1'b1);
        tick();
        drive(3, 3, 3, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        n_cmp++; if (out_valid_w !== 1'b1 || ovf_w !== 1'b1) begin n_bad++; $display("FAIL mid_full: got valid=%b ovf=%b expected 1 1", out_valid_w, ovf_w); end
        #2;
        Rst = 1'b0;
        #1;
        n_cmp++; if (out_valid_w !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid_w); end
        n_cmp++; if (z_w !== 8'sd0 || x_w !== 16'sd0) begin n_bad++; $display("FAIL mid_rst_data: got z=%0d x=%0d expected 0 0", z_w, x_w); end
        n_cmp++; if (ovf_w !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovf: got %b expected 0", ovf_w); end
        n_cmp++; if (in_ready_w !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready_w); end
        tick();
        Rst = 1'b1;
        out_ready = 1'b1;
        drive(3, 4, 5, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        n_cmp++; if (out_valid_w !== 1'b0) begin n_bad++; $display("FAIL mid_post_early: got %b expected 0", out_valid_w); end
        @(negedge Clk);
        n_cmp++; if (out_valid_w !== 1'b1 || z_w !== 8'sd7) begin n_bad++; $display("FAIL mid_post_result: got valid=%b z=%0d expected 1 7", out_valid_w, z_w); end
        tick();
    endtask

    task automatic test_random_sweep();
        bit     ovf_m [3];
        bit     clr_prev, head_seen, entered, exp_ir;
        int     n_in, n_out;
        exp_t   e, h;
        longint zr, xr, ze, xe;
        bit     ovr;
        logic [2:0] ovld, oovf, irdy;
        longint zo [3];
        longint xo [3];
        q.delete();
        n_in = 0;
        n_out = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) ovf_m[i] = 1'b0;
        clr_prev = 1'b0;
        head_seen = 1'b0;
        for (int cyc = 0; cyc < SWEEP + 40; cyc++) begin
            if (cyc < SWEEP) begin
                in_valid  = ($urandom_range(3) != 0);
                out_ready = ($urandom_range(2) != 0);
                ovf_clr   = ($urandom_range(7) == 0);
                a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom);
                a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 8'($urandom);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
                ovf_clr = 1'b0;
                if (q.size() == 0) break;
            end
            @(negedge Clk);
            ovld = {out_valid_l, out_valid_s, out_valid_w};
            oovf = {ovf_l, ovf_s, ovf_w};
            irdy = {in_ready_l, in_ready_s, in_ready_w};
            zo[0] = longint'(z_w); zo[1] = longint'(z_s); zo[2] = longint'(z_l);
            xo[0] = longint'(x_w); xo[1] = longint'(x_s); xo[2] = longint'(x_l);
            exp_ir = !(q.size() >= 2 && !out_ready);
            if (q.size() == 0 || q.size() >= 2 || head_seen) begin
                n_cmp++; if (ovld[2] !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_out_valid cyc %0d: got %b expected %b", cyc, ovld[2], q.size() != 0); end
            end
            entered = !head_seen && ovld[2] && (q.size() != 0);
            h = (q.size() != 0) ? q[0] : '0;
            for (int i = 0; i < 3; i++) begin
                ovf_m[i] = (entered && h.ov[i]) ? 1'b1 : (clr_prev ? 1'b0 : ovf_m[i]);
                n_cmp++; if (ovld[i] !== ovld[2]) begin n_bad++; $display("FAIL rnd_valid_agree cyc %0d dut %0d: got %b expected %b", cyc, i, ovld[i], ovld[2]); end
                n_cmp++; if (irdy[i] !== exp_ir) begin n_bad++; $display("FAIL rnd_in_ready cyc %0d dut %0d: got %b expected %b", cyc, i, irdy[i], exp_ir); end
                n_cmp++; if (oovf[i] !== ovf_m[i]) begin n_bad++; $display("FAIL rnd_ovf cyc %0d dut %0d: got %b expected %b", cyc, i, oovf[i], ovf_m[i]); end
                if (ovld[2] && q.size() != 0) begin
                    ze = longint'(h.z[i]);
                    xe = longint'(h.x[i]);
                    n_cmp++; if (zo[i] !== ze || xo[i] !== xe) begin
                        n_bad++; $display("FAIL rnd_data cyc %0d dut %0d: got z=%0d x=%0d expected z=%0d x=%0d", cyc, i, zo[i], xo[i], ze, xe);
                    end
                end
            end
            if (entered) head_seen = 1'b1;
            if (ovld[2] && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                head_seen = 1'b0;
                n_out++;
            end
            if (in_valid && exp_ir) begin
                ref_calc(longint'(a8), longint'(b8), longint'(c8), 8, 1'b0, zr, xr, ovr);
                e.z[0] = zr; e.x[0] = xr; e.ov[0] = ovr;
                ref_calc(longint'(a8), longint'(b8), longint'(c8), 8, 1'b1, zr, xr, ovr);
                e.z[1] = zr; e.x[1] = xr; e.ov[1] = ovr;
                ref_calc(longint'(a16), longint'(b16), longint'(c16), 16, 1'b1, zr, xr, ovr);
                e.z[2] = zr; e.x[2] = xr; e.ov[2] = ovr;
                q.push_back(e);
                n_in++;
            end
            clr_prev = ovf_clr;
            tick();
        end
        n_cmp++; if (q.size() != 0 || n_in != n_out) begin
            n_bad++; $display("FAIL rnd_drain: got %0d left, %0d in / %0d out expected 0 left and equal counts", q.size(), n_in, n_out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_midstream();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
